vga_pixel_shifter: RTL and testbench
====================================

Name: vga_pixel_shifter

Overview:
- Pixel back-end directly downstream of the CRTC/timing block.
- Per 8-pixel character slot it:
  - captures the VRAM byte addressed by the CRTC, plus row address, cursor, blank and sync flags;
  - drives the font ROM address and captures the glyph byte;
  - serialises the glyph MSB-first at pixel rate into foreground/background RGB.
- Sync and blank are delayed so they stay pixel-aligned with the video.

Parameters:
- RGB_W, 4, bits per colour channel.
- FG_RESET, 12'hFFF, foreground colour loaded at reset; {R,G,B}, each RGB_W wide.
- BG_RESET, 12'h000, background colour loaded at reset.

Ports:
- clk  in  1  pixel clock, same clock as the CRTC
- reset  in  1  asynchronous, active-low
- latch  in  1  active-low slot strobe; low for one clk per 8-clk slot
- vram_data  in  8  character code read at CRTC address; valid when latch is low
- ra  in  4  character row address from the CRTC
- cursor  in  1  cursor-at-this-cell flag from the CRTC
- blank  in  1  blanking from the CRTC, 1 = blank
- hsync_in  in  1  horizontal sync from the CRTC, active-low
- vsync_in  in  1  vertical sync from the CRTC, polarity passed through unchanged
- font_addr  out  12  font ROM address {code, row}
- font_data  in  8  font ROM output; must be stable before the next latch-low
- fg_color  in  3*RGB_W  foreground; sampled at slot boundary; FG_RESET is the reset default of the internal register
- bg_color  in  3*RGB_W  background; sampled at slot boundary
- red/green/blue  out  RGB_W each  pixel colour
- hsync  out  1  delayed hsync
- vsync  out  1  delayed vsync

Behaviour:
- Slot boundary: any posedge clk with latch==0. Consecutive low cycles are each treated as a boundary, with no error handling.
- Stage A (at boundary):
  - code_a<=vram_data, row_a<=ra;
  - cur_a/blk_a/hs_a/vs_a <= cursor/blank/hsync_in/vsync_in.
  - font_addr = {code_a, row_a}, registered, stable for the whole slot.
- Stage B (next boundary):
  - glyph_b <= font_data ^ {8{cur_a}} (cursor inverts the cell);
  - stage-A sidebands move to stage B;
  - fg/bg colour registers sample fg_color/bg_color.
- Shifter (at boundary):
  - sh<=glyph_b (stage-B value before its update), blk_s<=blk_b, hs_s<=hs_b, vs_s<=vs_b.
  - On other clocks: sh<=sh<<1, zero fill.
- Output register (every clk):
  - {red,green,blue} <= blk_s ? 0 : (sh[7] ? fg : bg);
  - hsync<=hs_s, vsync<=vs_s.
- Latency: data captured at boundary N first appears at the output 1 clk after boundary N+2, i.e. 17 clks. Pixel order is bit7 first.
- Sync/blank latency equals pixel latency exactly, with no skew between them.
- Reset values (async):
  - all RGB outputs 0; hsync=1, vsync=1;
  - font_addr=0; sh=0;
  - blank pipeline regs=1; sync pipeline regs=1;
  - fg=FG_RESET, bg=BG_RESET.
- Reset deassertion mid-line: output stays blanked until 3 boundaries have passed. No partial-slot garbage is allowed.
- Colour change mid-slot takes effect from the next slot's pixels onward.

Optional Feature:
- Macro: INVERSE_VIDEO_EN.
- With the macro defined:
  - vram_data[7] is an inverse-video attribute;
  - font_addr = {1'b0, code_a[6:0], row_a}, giving a 128-glyph font;
  - glyph_b <= font_data ^ {8{cur_a ^ inv_a}}, so cursor on an inverse cell shows normal video.
- Without the macro: the full 8-bit code is the glyph index (256 glyphs) and there is no attribute.

Test Plan:
- Reset with hsync_in=0, blank=0 → hsync=1, vsync=1, RGB=0, font_addr=0 until the third boundary after reset release.
- latch every 8 clks, vram_data=8'h41, ra=4'h3 → font_addr=12'h413 one clk after the boundary.
- font_data=8'b1010_0001, fg=12'hFFF, bg=12'h000, blank=0 → 17 clks after capture, 8 pixels are FFF,000,FFF,000,000,000,000,FFF.
- Same glyph with cursor=1 → inverted sequence 000,FFF,000,FFF,FFF,FFF,FFF,000.
- blank=1 for one slot, hsync_in low for one slot → RGB=0 for exactly 8 clks, and hsync low for exactly those same 8 clks.
- INVERSE_VIDEO_EN, vram_data=8'hC1, cursor=0 → font_addr=12'h413, glyph inverted; same input with cursor=1 → non-inverted glyph.

Source files
------------

// File: rtl/vga_pixel_shifter.sv
// vga_pixel_shifter
// Pixel back-end that sits directly behind the CRTC. In each 8-pixel character
// slot it captures the character code and sidebands, looks up the glyph in the
// font ROM, and shifts the glyph out MSB-first as foreground/background colour.
// Sync and blank go through the same number of stages as the pixels, so they
// stay aligned with the video.
//
// Optional feature macro: INVERSE_VIDEO_EN
//   When defined, vram_data[7] is an inverse-video attribute. The font is then
//   128 glyphs and is addressed by code[6:0]. When undefined, the full 8-bit
//   code selects one of 256 glyphs.

module vga_pixel_shifter #(
   parameter int                 RGB_W    = 4,
   parameter logic [3*RGB_W-1:0] FG_RESET = 12'hFFF,
   parameter logic [3*RGB_W-1:0] BG_RESET = 12'h000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               latch,
   input  logic [7:0]         vram_data,
   input  logic [3:0]         ra,
   input  logic               cursor,
   input  logic               blank,
   input  logic               hsync_in,
   input  logic               vsync_in,
   output logic [11:0]        font_addr,
   input  logic [7:0]         font_data,
   input  logic [3*RGB_W-1:0] fg_color,
   input  logic [3*RGB_W-1:0] bg_color,
   output logic [RGB_W-1:0]   red,
   output logic [RGB_W-1:0]   green,
   output logic [RGB_W-1:0]   blue,
   output logic               hsync,
   output logic               vsync
);

   localparam int CW = 3 * RGB_W;

   logic          boundary;

   logic [11:0]   fontAddr_q;
   logic [11:0]   fontAddr_d;
   logic          curA_q;
   logic          blkA_q;
   logic          hsA_q;
   logic          vsA_q;

   logic [7:0]    glyphB_q;
   logic [7:0]    glyph_d;
   logic          blkB_q;
   logic          hsB_q;
   logic          vsB_q;
   logic [CW-1:0] fg_q;
   logic [CW-1:0] bg_q;

   logic [7:0]    sh_q;
   logic [7:0]    sh_d;
   logic          blkS_q;
   logic          hsS_q;
   logic          vsS_q;

   logic [CW-1:0] rgb_q;
   logic [CW-1:0] rgb_d;
   logic          hsync_q;
   logic          vsync_q;

   // latch is an active-low strobe; every low cycle counts as a new slot.
   assign boundary = ~latch;

`ifdef INVERSE_VIDEO_EN
   logic invA_q;

   // Bit 7 of the code is the inverse attribute, so the font only sees 7 bits.
   assign fontAddr_d = {1'b0, vram_data[6:0], ra};
   assign glyph_d    = font_data ^ {8{curA_q ^ invA_q}};

   // The inverse attribute travels with the stage-A capture of its cell.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         invA_q <= 1'b0;
      end else if (boundary) begin
         invA_q <= vram_data[7];
      end
   end
`else
   assign fontAddr_d = {vram_data, ra};
   assign glyph_d    = font_data ^ {8{curA_q}};
`endif

   // Stage A: capture the cell from the CRTC and hold the font address for the slot.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fontAddr_q <= '0;
         curA_q     <= 1'b0;
         blkA_q     <= 1'b1;
         hsA_q      <= 1'b1;
         vsA_q      <= 1'b1;
      end else if (boundary) begin
         fontAddr_q <= fontAddr_d;
         curA_q     <= cursor;
         blkA_q     <= blank;
         hsA_q      <= hsync_in;
         vsA_q      <= vsync_in;
      end
   end

   assign font_addr = fontAddr_q;

   // Stage B: take the glyph the ROM produced over the last slot and sample the colours.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         glyphB_q <= '0;
         blkB_q   <= 1'b1;
         hsB_q    <= 1'b1;
         vsB_q    <= 1'b1;
         fg_q     <= FG_RESET;
         bg_q     <= BG_RESET;
      end else if (boundary) begin
         glyphB_q <= glyph_d;
         blkB_q   <= blkA_q;
         hsB_q    <= hsA_q;
         vsB_q    <= vsA_q;
         fg_q     <= fg_color;
         bg_q     <= bg_color;
      end
   end

   // Shifter next state and pixel colour selection; blank forces black.
   always_comb begin
      sh_d = {sh_q[6:0], 1'b0};
      if (boundary) begin
         sh_d = glyphB_q;
      end
      rgb_d = '0;
      if (!blkS_q) begin
         rgb_d = sh_q[7] ? fg_q : bg_q;
      end
   end

   // Shifter stage: load the stage-B glyph at the boundary, otherwise shift left.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sh_q   <= '0;
         blkS_q <= 1'b1;
         hsS_q  <= 1'b1;
         vsS_q  <= 1'b1;
      end else begin
         sh_q <= sh_d;
         if (boundary) begin
            blkS_q <= blkB_q;
            hsS_q  <= hsB_q;
            vsS_q  <= vsB_q;
         end
      end
   end

   // Output register: one more clock so colour and syncs leave from flops together.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rgb_q   <= '0;
         hsync_q <= 1'b1;
         vsync_q <= 1'b1;
      end else begin
         rgb_q   <= rgb_d;
         hsync_q <= hsS_q;
         vsync_q <= vsS_q;
      end
   end

   assign red   = rgb_q[CW-1 -: RGB_W];
   assign green = rgb_q[2*RGB_W-1 -: RGB_W];
   assign blue  = rgb_q[RGB_W-1:0];
   assign hsync = hsync_q;
   assign vsync = vsync_q;

endmodule

// File: tb/tb_vga_pixel_shifter.sv
// tb_vga_pixel_shifter
// Drives character slots every 8 clocks and predicts, one slot at a time, the
// eight pixels plus syncs that must appear two slots later. Predictions go into
// a queue when a slot is driven and are popped every clock once output starts.

module tb_vga_pixel_shifter;

   localparam int RGB_W = 4;

   typedef struct {
      logic [7:0]  code;
      logic [3:0]  ra;
      logic        cur;
      logic        blk;
      logic        hs;
      logic        vs;
      logic [11:0] fg;
      logic [11:0] bg;
   } slot_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        latch;
   logic [7:0]  vramData;
   logic [3:0]  ra;
   logic        cursor;
   logic        blank;
   logic        hsyncIn;
   logic        vsyncIn;
   logic [11:0] fontAddr;
   logic [7:0]  fontData;
   logic [11:0] fgColor;
   logic [11:0] bgColor;
   logic [3:0]  red;
   logic [3:0]  green;
   logic [3:0]  blue;
   logic        hsync;
   logic        vsync;

   int          compared   = 0;
   int          mismatched = 0;

   slot_t       stim[$];
   logic [15:0] expQ[$];
   slot_t       hist1;
   slot_t       hist2;
   logic        firstPush;
   logic        addrPending;
   logic [11:0] addrExp;

   vga_pixel_shifter #(
      .RGB_W(RGB_W),
      .FG_RESET(12'hFFF),
      .BG_RESET(12'h000)
   ) dut (
      .clk(clk),
      .reset(reset),
      .latch(latch),
      .vram_data(vramData),
      .ra(ra),
      .cursor(cursor),
      .blank(blank),
      .hsync_in(hsyncIn),
      .vsync_in(vsyncIn),
      .font_addr(fontAddr),
      .font_data(fontData),
      .fg_color(fgColor),
      .bg_color(bgColor),
      .red(red),
      .green(green),
      .blue(blue),
      .hsync(hsync),
      .vsync(vsync)
   );

   always #5 clk = ~clk;

   // Font ROM stand-in: the test-plan glyph at 0x413, a scrambled pattern elsewhere.
   function automatic logic [7:0] romModel(input logic [11:0] a);
      if (a == 12'h413) return 8'hA1;
      return a[11:4] ^ {a[3:0], ~a[3:0]} ^ 8'h5B;
   endfunction

   assign fontData = romModel(fontAddr);

   function automatic logic [11:0] expAddr(input slot_t s);
`ifdef INVERSE_VIDEO_EN
      return {1'b0, s.code[6:0], s.ra};
`else
      return {s.code, s.ra};
`endif
   endfunction

   function automatic logic [7:0] expGlyph(input slot_t s);
`ifdef INVERSE_VIDEO_EN
      return romModel(expAddr(s)) ^ {8{s.cur ^ s.code[7]}};
`else
      return romModel(expAddr(s)) ^ {8{s.cur}};
`endif
   endfunction

   function automatic slot_t mkSlot(input logic [7:0] code, input logic [3:0] r,
                                    input logic cur, input logic blk, input logic hs,
                                    input logic vs, input logic [11:0] fg,
                                    input logic [11:0] bg);
      slot_t s;
      s.code = code; s.ra = r; s.cur = cur; s.blk = blk;
      s.hs = hs; s.vs = vs; s.fg = fg; s.bg = bg;
      return s;
   endfunction

   task automatic checkOutput(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Drive a slot boundary and queue the pixels due in the slot that starts here.
   task automatic applyStimulus(input slot_t s);
      logic [7:0]  g;
      logic [11:0] pix;
      latch    = 1'b0;
      vramData = s.code;
      ra       = s.ra;
      cursor   = s.cur;
      blank    = s.blk;
      hsyncIn  = s.hs;
      vsyncIn  = s.vs;
      fgColor  = s.fg;
      bgColor  = s.bg;
      addrExp     = expAddr(s);
      addrPending = 1'b1;
      if (firstPush) begin
         expQ.push_back({2'b00, 12'h000, 1'b1, 1'b1});
         firstPush = 1'b0;
      end
      g = expGlyph(hist2);
      for (int j = 0; j < 8; j++) begin
         pix = hist2.blk ? 12'h000 : (g[7-j] ? s.fg : s.bg);
         expQ.push_back({2'b00, pix, hist2.hs, hist2.vs});
      end
      hist2 = hist1;
      hist1 = s;
   endtask

   task automatic popAndCheck();
      logic [15:0] e;
      if (expQ.size() > 0) begin
         e = expQ.pop_front();
         checkOutput("pixel", {2'b00, red, green, blue, hsync, vsync}, e);
      end
   endtask

   initial begin
      slot_t rst;
      rst = mkSlot(8'h00, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 12'h000, 12'h000);
      hist1       = rst;
      hist2       = rst;
      firstPush   = 1'b1;
      addrPending = 1'b0;
      addrExp     = '0;

      stim.push_back(mkSlot(8'h41, 4'h3, 1'b0, 1'b0, 1'b0, 1'b1, 12'hFFF, 12'h000));
      stim.push_back(mkSlot(8'h41, 4'h3, 1'b0, 1'b0, 1'b1, 1'b1, 12'hFFF, 12'h000));
      stim.push_back(mkSlot(8'h41, 4'h3, 1'b1, 1'b0, 1'b1, 1'b1, 12'hFFF, 12'h000));
      stim.push_back(mkSlot(8'h41, 4'h3, 1'b0, 1'b1, 1'b0, 1'b1, 12'hFFF, 12'h000));
      stim.push_back(mkSlot(8'h7E, 4'h5, 1'b0, 1'b0, 1'b1, 1'b0, 12'hFFF, 12'h000));
      stim.push_back(mkSlot(8'hC1, 4'h3, 1'b0, 1'b0, 1'b1, 1'b1, 12'h0F0, 12'h00F));
      stim.push_back(mkSlot(8'hC1, 4'h3, 1'b1, 1'b0, 1'b1, 1'b1, 12'h0F0, 12'h00F));
      stim.push_back(mkSlot(8'h41, 4'h3, 1'b0, 1'b0, 1'b1, 1'b1, 12'hA5C, 12'h3C1));
      for (int i = 0; i < 4; i++) begin
         stim.push_back(mkSlot(8'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
                               1'($urandom), 1'($urandom), 12'($urandom), 12'($urandom)));
      end
      stim.push_back(mkSlot(8'h20, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 12'h123, 12'h456));
      stim.push_back(mkSlot(8'h20, 4'h1, 1'b0, 1'b1, 1'b1, 1'b1, 12'h789, 12'hABC));

      // Reset asserted with sync low and blank off on the inputs.
      reset    = 1'b0;
      latch    = 1'b1;
      vramData = 8'h55;
      ra       = 4'h7;
      cursor   = 1'b0;
      blank    = 1'b0;
      hsyncIn  = 1'b0;
      vsyncIn  = 1'b0;
      fgColor  = 12'h321;
      bgColor  = 12'h654;
      repeat (3) @(negedge clk);
      checkOutput("rstRgb", {4'h0, red, green, blue}, 16'h0000);
      checkOutput("rstSync", {14'h0, hsync, vsync}, 16'h0003);
      checkOutput("rstAddr", {4'h0, fontAddr}, 16'h0000);
      reset = 1'b1;

      // Mid-line release: idle clocks before the first boundary stay at reset values.
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checkOutput("preBoundary", {2'b00, red, green, blue, hsync, vsync}, 16'h0003);
      end

      for (int k = 0; k < stim.size(); k++) begin
         for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            popAndCheck();
            if (addrPending) begin
               checkOutput("fontAddr", {4'h0, fontAddr}, {4'h0, addrExp});
               addrPending = 1'b0;
            end
            if (c == 0) begin
               applyStimulus(stim[k]);
            end else begin
               latch    = 1'b1;
               vramData = 8'($urandom);
               ra       = 4'($urandom);
               cursor   = 1'($urandom);
               blank    = 1'($urandom);
               hsyncIn  = 1'($urandom);
               vsyncIn  = 1'($urandom);
            end
            if (c == 4 && k + 1 < stim.size()) begin
               fgColor = stim[k+1].fg;
               bgColor = stim[k+1].bg;
            end
         end
      end

      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         latch = 1'b1;
         if (expQ.size() > 0) popAndCheck();
      end
      checkOutput("drained", 16'(expQ.size()), 16'h0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
